// File: rtl/layers_priority_mux_pkg.sv
// Shared constants and types for the layer compositor and its priority table.
package layers_priority_mux_pkg;

  localparam int DEF_NUM_LAYERS = 8;
  localparam int DEF_RGB_W      = 8;
  localparam logic [DEF_RGB_W-1:0] DEF_TRANSPARENT = 8'hFF;
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_LAYERS);

  typedef logic [DEF_IDX_W-1:0] layer_idx_t;

  // winner_id MSB set means no layer won and the background colour was chosen
  localparam logic WINNER_BG_FLAG = 1'b1;

  function automatic logic [DEF_IDX_W:0] bg_winner_id();
    return {WINNER_BG_FLAG, {DEF_IDX_W{1'b0}}};
  endfunction

endpackage

// File: rtl/layers_priority_mux_priority_table.sv
// Slot-to-layer priority table: one write port, every slot readable combinationally.
module priority_table
  import layers_priority_mux_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int IW         = $clog2(DEF_NUM_LAYERS)
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [IW-1:0]                 cfg_slot,
  input  logic [IW-1:0]                 cfg_layer,
  output logic [NUM_LAYERS-1:0][IW-1:0] rd_layer
);

  logic [NUM_LAYERS-1:0][IW-1:0] r_tbl;
  logic                          w_wr_ok;

  // Out-of-range slot or layer indices are dropped so the table only ever holds real layers
  assign w_wr_ok = cfg_we && (int'(cfg_slot) < NUM_LAYERS) && (int'(cfg_layer) < NUM_LAYERS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_tbl[k] <= IW'(k);
      end
    end else if (w_wr_ok) begin
      r_tbl[cfg_slot] <= cfg_layer;
    end
  end

  assign rd_layer = r_tbl;

endmodule

// File: rtl/layers_priority_mux.sv
// Two-stage layer compositor: qualify active layers, then pick the winner through
// the priority table and track per-frame layer overlaps.
module layers_priority_mux
  import layers_priority_mux_pkg::*;
#(
  parameter int                NUM_LAYERS  = DEF_NUM_LAYERS,
  parameter int                RGB_W       = DEF_RGB_W,
  parameter logic [RGB_W-1:0]  TRANSPARENT = RGB_W'(DEF_TRANSPARENT),
  localparam int               IW          = $clog2(NUM_LAYERS)
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pixel_valid,
  input  logic                             frame_start,
  input  logic [NUM_LAYERS-1:0]            draw_req,
  input  logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb_layers,
  input  logic [RGB_W-1:0]                 rgb_background,
  input  logic [NUM_LAYERS-1:0]            layer_enable,
  input  logic                             cfg_we,
  input  logic [IW-1:0]                    cfg_slot,
  input  logic [IW-1:0]                    cfg_layer,
  output logic [RGB_W-1:0]                 rgb_out,
  output logic                             rgb_out_valid,
  output logic [IW:0]                      winner_id,
  output logic [NUM_LAYERS-1:0]            collided,
  output logic [NUM_LAYERS-1:0]            collided_last
);

  localparam logic [IW:0] WINNER_BG = {WINNER_BG_FLAG, {IW{1'b0}}};

  logic [NUM_LAYERS-1:0]            w_active;
  logic [NUM_LAYERS-1:0]            r_s1_active;
  logic [NUM_LAYERS-1:0][RGB_W-1:0] r_s1_rgb;
  logic [RGB_W-1:0]                 r_s1_bg;
  logic                             r_s1_valid;
  logic                             r_s1_fs;

  logic [NUM_LAYERS-1:0][IW-1:0]    w_tbl;
  logic                             w_found;
  logic [IW-1:0]                    w_win;
  logic                             w_coll;

  logic [RGB_W-1:0]                 r_rgb;
  logic                             r_valid;
  logic [IW:0]                      r_wid;
  logic [NUM_LAYERS-1:0]            r_coll;
  logic [NUM_LAYERS-1:0]            r_coll_last;

  always_comb begin
    w_active = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_active[k] = draw_req[k] & layer_enable[k] & (rgb_layers[k] != TRANSPARENT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_active <= '0;
      r_s1_rgb    <= '0;
      r_s1_bg     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_fs     <= 1'b0;
    end else begin
      r_s1_active <= w_active;
      r_s1_rgb    <= rgb_layers;
      r_s1_bg     <= rgb_background;
      r_s1_valid  <= pixel_valid;
      r_s1_fs     <= frame_start;
    end
  end

  priority_table #(
    .NUM_LAYERS (NUM_LAYERS),
    .IW         (IW)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_slot  (cfg_slot),
    .cfg_layer (cfg_layer),
    .rd_layer  (w_tbl)
  );

  // Scan from the lowest priority slot up so the highest-priority active slot is the last to land
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if (r_s1_active[w_tbl[s]]) begin
        w_found = 1'b1;
        w_win   = w_tbl[s];
      end
    end
  end

  assign w_coll = r_s1_valid && ($countones(r_s1_active) >= 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb       <= '0;
      r_valid     <= 1'b0;
      r_wid       <= WINNER_BG;
      r_coll      <= '0;
      r_coll_last <= '0;
    end else begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rgb <= w_found ? r_s1_rgb[w_win] : r_s1_bg;
        r_wid <= w_found ? {1'b0, w_win} : WINNER_BG;
      end
      // A frame_start pixel's own overlaps belong to the new frame, so they survive the clear
      if (r_s1_fs) begin
        r_coll_last <= r_coll;
        r_coll      <= w_coll ? r_s1_active : '0;
      end else if (w_coll) begin
        r_coll <= r_coll | r_s1_active;
      end
    end
  end

  assign rgb_out       = r_rgb;
  assign rgb_out_valid = r_valid;
  assign winner_id     = r_wid;
  assign collided      = r_coll;
  assign collided_last = r_coll_last;

endmodule

// File: tb/tb_layers_priority_mux.sv
// Self-checking bench for layers_priority_mux: directed vector table, random stream
// against a behavioural model, valid toggling and asynchronous reset.
module tb_layers_priority_mux;
  import layers_priority_mux_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            d_valid, d_fs, d_we;
  logic [7:0]      d_draw, d_en, d_bg;
  logic [7:0][7:0] d_rgb;
  logic [2:0]      d_slot, d_layer;

  logic [7:0] rgb_out;
  logic       rgb_out_valid;
  logic [3:0] winner_id;
  logic [7:0] collided, collided_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layers_priority_mux dut (
    .clk            (clk),
    .reset          (reset),
    .pixel_valid    (d_valid),
    .frame_start    (d_fs),
    .draw_req       (d_draw),
    .rgb_layers     (d_rgb),
    .rgb_background (d_bg),
    .layer_enable   (d_en),
    .cfg_we         (d_we),
    .cfg_slot       (d_slot),
    .cfg_layer      (d_layer),
    .rgb_out        (rgb_out),
    .rgb_out_valid  (rgb_out_valid),
    .winner_id      (winner_id),
    .collided       (collided),
    .collided_last  (collided_last)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic            valid;
    logic            fs;
    logic [7:0]      act;
    logic [7:0][7:0] rgb;
    logic [7:0]      bg;
  } mpix_t;

  int         m_tbl[8];
  mpix_t      m_s1;
  logic [7:0] e_rgb, e_coll, e_last;
  logic [3:0] e_wid;
  logic       e_valid;

  function automatic mpix_t make_pix();
    mpix_t p;
    p.valid = d_valid;
    p.fs    = d_fs;
    p.rgb   = d_rgb;
    p.bg    = d_bg;
    for (int k = 0; k < 8; k++) p.act[k] = d_draw[k] && d_en[k] && (d_rgb[k] != 8'hFF);
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_tbl[k] = k;
    m_s1.valid = 0; m_s1.fs = 0; m_s1.act = 0; m_s1.rgb = '0; m_s1.bg = 0;
    e_rgb = 0; e_valid = 0; e_wid = bg_winner_id(); e_coll = 0; e_last = 0;
  endtask

  task automatic model_stage2();
    int  win;
    int  n;
    win = -1;
    n   = $countones(m_s1.act);
    e_valid = m_s1.valid;
    if (m_s1.valid) begin
      for (int s = 0; s < 8; s++)
        if (win < 0 && m_s1.act[m_tbl[s]]) win = m_tbl[s];
      e_rgb = (win >= 0) ? m_s1.rgb[win] : m_s1.bg;
      e_wid = (win >= 0) ? 4'(win) : 4'b1000;
    end
    if (m_s1.fs) begin
      e_last = e_coll;
      e_coll = (m_s1.valid && n >= 2) ? m_s1.act : 8'h00;
    end else if (m_s1.valid && n >= 2) begin
      e_coll = e_coll | m_s1.act;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model.rgb_out", 64'(rgb_out), 64'(e_rgb));
    chk("model.rgb_out_valid", 64'(rgb_out_valid), 64'(e_valid));
    chk("model.winner_id", 64'(winner_id), 64'(e_wid));
    chk("model.collided", 64'(collided), 64'(e_coll));
    chk("model.collided_last", 64'(collided_last), 64'(e_last));
  endtask

  task automatic step();
    mpix_t p;
    p = make_pix();
    @(posedge clk);
    model_stage2();
    if (d_we) m_tbl[d_slot] = int'(d_layer);
    m_s1 = p;
    #1;
    check_model();
  endtask

  task automatic drive_idle();
    d_valid = 0; d_fs = 0; d_we = 0; d_slot = 0; d_layer = 0;
  endtask

  task automatic drive_random();
    d_valid = ($urandom_range(0, 3) != 0);
    d_fs    = ($urandom_range(0, 15) == 0);
    d_we    = ($urandom_range(0, 7) == 0);
    d_slot  = 3'($urandom);
    d_layer = 3'($urandom);
    d_draw  = 8'($urandom);
    d_en    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
    d_bg    = 8'($urandom);
    for (int k = 0; k < 8; k++) d_rgb[k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rgb_out"}, 64'(rgb_out), 64'h0);
    chk({tag, ".rgb_out_valid"}, 64'(rgb_out_valid), 64'h0);
    chk({tag, ".winner_id"}, 64'(winner_id), 64'h8);
    chk({tag, ".collided"}, 64'(collided), 64'h0);
    chk({tag, ".collided_last"}, 64'(collided_last), 64'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            we;
    logic [2:0]      slot, layer;
    logic            valid, fs;
    logic [7:0]      draw, en, bg;
    logic [7:0][7:0] rgb;
    logic [7:0]      x_rgb;
    logic [3:0]      x_wid;
    logic            x_valid;
    logic [7:0]      x_coll, x_last;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] slot, input logic [2:0] layer,
                              input logic valid, input logic fs, input logic [7:0] draw,
                              input logic [7:0] en, input logic [63:0] rgb,
                              input logic [7:0] x_rgb, input logic [3:0] x_wid,
                              input logic x_valid, input logic [7:0] x_coll,
                              input logic [7:0] x_last);
    vec_t v;
    v.we = we; v.slot = slot; v.layer = layer; v.valid = valid; v.fs = fs;
    v.draw = draw; v.en = en; v.bg = 8'h55; v.rgb = rgb;
    v.x_rgb = x_rgb; v.x_wid = x_wid; v.x_valid = x_valid; v.x_coll = x_coll; v.x_last = x_last;
    return v;
  endfunction

  localparam logic [63:0] RGB_L12   = 64'h0000_0000_00E0_1C00;
  localparam logic [63:0] RGB_L1T   = 64'h0000_0000_00E0_FF00;
  localparam logic [63:0] RGB_L35   = 64'h0000_7700_3300_0000;
  localparam logic [63:0] RGB_L0    = 64'h0000_0000_0000_000A;
  localparam logic [63:0] RGB_L03   = 64'h0000_0000_3300_000A;

  vec_t vecs[10];

  initial begin
    vecs[0] = mk(0, 0, 0, 1, 0, 8'h06, 8'hFF, RGB_L12, 8'h1C, 4'd1, 1, 8'h06, 8'h00);
    vecs[1] = mk(1, 0, 2, 1, 0, 8'h06, 8'hFF, RGB_L12, 8'hE0, 4'd2, 1, 8'h06, 8'h00);
    vecs[2] = mk(0, 0, 0, 1, 0, 8'h02, 8'hFF, RGB_L1T, 8'h55, 4'h8, 1, 8'h06, 8'h00);
    vecs[3] = mk(0, 0, 0, 1, 1, 8'h00, 8'hFF, RGB_L12, 8'h55, 4'h8, 1, 8'h00, 8'h06);
    vecs[4] = mk(0, 0, 0, 1, 0, 8'h28, 8'hFF, RGB_L35, 8'h33, 4'd3, 1, 8'h28, 8'h06);
    vecs[5] = mk(0, 0, 0, 1, 1, 8'h01, 8'hFF, RGB_L0,  8'h55, 4'h8, 1, 8'h00, 8'h28);
    vecs[6] = mk(0, 0, 0, 1, 0, 8'h06, 8'hFF, RGB_L12, 8'hE0, 4'd2, 1, 8'h06, 8'h28);
    vecs[7] = mk(0, 0, 0, 0, 1, 8'h28, 8'hFF, RGB_L35, 8'hE0, 4'd2, 0, 8'h00, 8'h06);
    vecs[8] = mk(0, 0, 0, 1, 0, 8'hFF, 8'h04, RGB_L12, 8'hE0, 4'd2, 1, 8'h00, 8'h06);
    vecs[9] = mk(1, 3, 0, 1, 0, 8'h09, 8'hFF, RGB_L03, 8'h0A, 4'd0, 1, 8'h09, 8'h06);

    reset = 1;
    drive_idle();
    d_draw = 0; d_en = 0; d_bg = 0; d_rgb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    #2 reset = 0;

    for (int i = 0; i < 10; i++) begin
      d_we = vecs[i].we; d_slot = vecs[i].slot; d_layer = vecs[i].layer;
      d_valid = vecs[i].valid; d_fs = vecs[i].fs; d_draw = vecs[i].draw;
      d_en = vecs[i].en; d_bg = vecs[i].bg; d_rgb = vecs[i].rgb;
      step();
      drive_idle();
      step();
      chk($sformatf("vec%0d.rgb_out", i), 64'(rgb_out), 64'(vecs[i].x_rgb));
      chk($sformatf("vec%0d.winner_id", i), 64'(winner_id), 64'(vecs[i].x_wid));
      chk($sformatf("vec%0d.rgb_out_valid", i), 64'(rgb_out_valid), 64'(vecs[i].x_valid));
      chk($sformatf("vec%0d.collided", i), 64'(collided), 64'(vecs[i].x_coll));
      chk($sformatf("vec%0d.collided_last", i), 64'(collided_last), 64'(vecs[i].x_last));
    end

    // pixel_valid toggling every cycle with overlapping layers
    for (int i = 0; i < 12; i++) begin
      drive_random();
      d_fs = 0; d_we = 0;
      d_valid = i[0];
      d_draw = d_draw | 8'h03;
      step();
    end

    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    // asynchronous reset between edges with a valid pixel in flight
    drive_random();
    d_valid = 1;
    step();
    d_valid = 1;
    #2 reset = 1;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    drive_idle();
    @(posedge clk);
    #3 reset = 0;
    step();
    chk("post_reset.inflight_dropped", 64'(rgb_out_valid), 64'h0);

    d_valid = 1; d_draw = 8'h06; d_en = 8'hFF; d_rgb = RGB_L12; d_bg = 8'h55;
    step();
    drive_idle();
    step();
    chk("post_reset.identity_rgb", 64'(rgb_out), 64'h1C);
    chk("post_reset.identity_wid", 64'(winner_id), 64'h1);
    chk("post_reset.collided", 64'(collided), 64'h06);

    for (int i = 0; i < 100; i++) begin
      drive_random();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layers_priority_mux.md
LAYERS_PRIORITY_MUX -- requirements
Module: layers_priority_mux

Interface
REQ-001 Parameter NUM_LAYERS, default 8: number of drawable layers, legal range 2..16.
REQ-002 Parameter RGB_W, default 8: pixel colour width in bits.
REQ-003 Parameter TRANSPARENT, default 8'hFF (RGB_W bits): colour key; a layer pixel equal to it is treated as not drawing.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixel_valid  input  1  input pixel qualifier.
REQ-007 frame_start  input  1  one-cycle pulse marking the first pixel of a frame.
REQ-008 draw_req  input  NUM_LAYERS  per-layer drawing request.
REQ-009 rgb_layers  input  NUM_LAYERS x RGB_W  per-layer colour.
REQ-010 rgb_background  input  RGB_W  colour used when no layer wins.
REQ-011 layer_enable  input  NUM_LAYERS  per-layer enable mask.
REQ-012 cfg_we, cfg_slot, cfg_layer  input  1, clog2(NUM_LAYERS), clog2(NUM_LAYERS)  priority-table write port.
REQ-013 rgb_out  output  RGB_W  composited pixel, registered.
REQ-014 rgb_out_valid  output  1  qualifier of rgb_out.
REQ-015 winner_id  output  clog2(NUM_LAYERS)+1  winning layer index; MSB set means background.
REQ-016 collided  output  NUM_LAYERS  sticky per-layer overlap flags for the current frame.
REQ-017 collided_last  output  NUM_LAYERS  snapshot of collided taken at frame_start.

Function
REQ-018 Stage 1 registers the active vector: draw_req & layer_enable & (rgb_layers != TRANSPARENT), together with the colours, background, pixel_valid and frame_start.
REQ-019 Stage 2 selects the winner through the priority table and registers rgb_out, winner_id and rgb_out_valid; input-to-output latency is exactly 2 cycles, with 1 pixel per cycle and no stalls.
REQ-020 Priority table: NUM_LAYERS slots, each holding a layer index; slot 0 has the highest priority.
REQ-021 The winner is the layer in the lowest-numbered slot whose layer is active; if none is active, rgb_out = background and winner_id MSB = 1.
REQ-022 A layer listed in several slots takes the highest-priority slot; a layer absent from the table never wins but still counts toward collisions.
REQ-023 The write cfg_we=1 sets table[cfg_slot] = cfg_layer at the clock edge; stage 2 uses the new value from the next cycle onward.
REQ-024 Writes with cfg_slot >= NUM_LAYERS or cfg_layer >= NUM_LAYERS are ignored.
REQ-025 When pixel_valid=0 at stage 2, rgb_out_valid=0, rgb_out and winner_id hold their previous values, and collision flags are not updated.
REQ-026 A collision occurs when a stage-2 pixel is valid and at least 2 bits of its active vector are set; every active layer's collided bit is then set to 1.
REQ-027 When frame_start reaches stage 2, collided_last is loaded with collided, then collided clears to 0; collisions from that same pixel are written after the clear, so they belong to the new frame.
REQ-028 A frame_start with pixel_valid=0 still performs the snapshot and clear.

Reset
REQ-029 While reset=1: rgb_out=0, rgb_out_valid=0, winner_id={1,0...}, collided=0, collided_last=0, all pipeline registers =0, and table[k]=k (layer 0 highest).
REQ-030 Reset asserted mid-frame discards in-flight pixels; the first valid output appears 2 cycles after the first valid input following deassertion.

Structure
REQ-031 The shared package holds the default NUM_LAYERS, RGB_W and TRANSPARENT constants, the layer-index typedef, and the background winner_id encoding.
REQ-032 The priority table is a sub-module named priority_table, with a write port and NUM_LAYERS combinational read ports; the rest of the logic stays in layers_priority_mux.

Verification
REQ-033 After reset, with draw_req=8'h06, layer1=8'h1C, layer2=8'hE0 and all enabled -> 2 cycles later rgb_out=8'h1C, winner_id=1, and collided bits 1 and 2 are set.
REQ-034 Write slot0=layer2 and then apply the REQ-033 pixel -> rgb_out=8'hE0, winner_id=2.
REQ-035 Set layer1=8'hFF with draw_req=8'h02 -> rgb_out=rgb_background, winner_id MSB=1, collided unchanged.
REQ-036 Collision on bits 3 and 5, then a frame_start pixel with no overlap -> collided_last=8'h28 and collided=8'h00.
REQ-037 Toggle pixel_valid every cycle -> rgb_out_valid follows with 2-cycle latency and flags update only on valid pixels.
REQ-038 Assert reset asynchronously between clock edges mid-stream -> outputs go to reset values immediately and the table returns to identity.
